ma_filter_mc: RTL and testbench
===============================

# ma_filter_mc

Multi-channel, time-multiplexed moving-average filter with a valid-qualified input and a runtime-selectable power-of-two window. It is the parametrised successor to the single-channel fixed-order moving-average filter. It sits between a sample source, such as an ADC front end or TDM demux, and downstream decimation and logging. One instance serves up to CHANNELS interleaved streams at one sample per clock, with no backpressure.

## Interface
- INPUT_WIDTH, 16, sample width.
- OUTPUT_WIDTH, 18, result width; must be ≥ INPUT_WIDTH, otherwise elaboration error.
- MAX_ORDER, 4, log2 of the maximum window (history depth 2^MAX_ORDER per channel).
- CHANNELS, 4, number of independent channels.
- SIGNED, 0, 1 means samples and results are two's complement.
- ROUND, 0, 0 means truncate (floor); 1 means round-half-up.
- CW (derived) = max(1, $clog2(CHANNELS)); OW (derived) = $clog2(MAX_ORDER+1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  sample strobe.
- in_chan  in  CW  channel of the sample.
- data  in  INPUT_WIDTH  sample.
- order  in  OW  window log2, N = 2^order; values > MAX_ORDER are clamped to MAX_ORDER.
- clear  in  1  synchronous flush of all channels.
- out_valid  out  1  result strobe.
- out_chan  out  CW  channel of the result.
- result  out  OUTPUT_WIDTH  window mean, sign-extended (SIGNED=1) or zero-extended.
- out_full  out  1  window held ≥ N real samples when this result was computed.

## Operation
- Per-channel state:
  - circular history of 2^MAX_ORDER samples, kept in flops;
  - write pointer;
  - accumulator of INPUT_WIDTH+MAX_ORDER bits;
  - fill counter, saturating at 2^MAX_ORDER.
- On an accepted sample x on channel c:
  - x_old = hist[c][(wp[c] − N) mod 2^MAX_ORDER];
  - acc[c] ← acc[c] + x − x_old;
  - hist[c][wp[c]] ← x;
  - wp[c] increments with wrap;
  - fill[c] increments (saturating).
- Mean = (acc + (ROUND && order>0 ? 2^(order−1) : 0)) >> order. The shift is arithmetic when SIGNED=1, so truncation floors toward −∞. The mean always fits INPUT_WIDTH and is then extended to OUTPUT_WIDTH.
- The window starts zero-filled: the first N−1 outputs after a flush average real samples with zeros. out_full = (fill including the current sample ≥ N).
- A flush zeroes every channel's history, accumulator, pointer and fill counter. Flush sources:
  - nrst low;
  - clear = 1;
  - the clamped order differing from its registered copy (order change).
- in_valid together with flush in the same cycle: flush has priority. The sample is then processed against the zeroed state as the first sample of its channel.
- in_chan ≥ CHANNELS: the sample is ignored; no state change and no output.
- Channels are fully independent; any interleaving is allowed, including back-to-back on the same channel.

## Timing
- Two-stage pipeline; no stalls; throughput one sample per cycle.
- Stage 1, at the edge ending cycle n when in_valid=1: accumulator/history update; registers sum, channel, order and full flag.
- Stage 2, next edge: shift/round/extend into result; out_valid=1, out_chan and out_full are valid during cycle n+2.
- out_valid is a one-cycle strobe per accepted sample. Between strobes, result, out_chan and out_full hold their last values.
- Reset values: out_valid=0, out_chan=0, result=0, out_full=0; all internal state zero.
- Reset asserted mid-stream: outputs clear immediately (asynchronously) and in-flight samples are dropped.
- Flush does not cancel results already in stage 1/2. Those results complete with their old values.
- Accumulator never overflows: |acc| ≤ 2^MAX_ORDER·max|x| fits INPUT_WIDTH+MAX_ORDER bits.

## Test plan
- Reset/basic: during reset all outputs 0. Then order=2, ch0 constant 100 every cycle → results 25, 50, 75, 100, 100…; out_full 0,0,0,1,1…; first out_valid in cycle n+2 after the first in_valid.
- Interleave: order=1, alternate ch0=1000 and ch1=0, plus one in_chan=5 sample → ch0 results 500, 1000, 1000…; ch1 always 0; the ch5 sample produces no out_valid.
- Signed/rounding: SIGNED=1, order=1, ch0 samples −3 then 0 → second result −2 (0x3FFFE) with ROUND=0, −1 (0x3FFFF) with ROUND=1. Samples −4, −4 → −4 in both modes.
- Flush: stream 80 on ch0 with order=2, change order to 3 → next sample 80 gives result 10 with out_full=0. Separately, clear=1 with in_valid ch2 data=40, order=2 → result 10.
- Range/clamp: order=7 (clamped to 4), sixteen samples 0xFFFF → 16th result 0x0FFFF with out_full=1; no wrap.
- Async reset mid-stream: nrst low while two samples are in flight → out_valid drops immediately with no late strobe. After release, the first ch0 sample 100 at order=2 gives result 25.

Source files
------------

// File: rtl/ma_filter_mc.sv
`default_nettype none
// ============================================================================
// Module      : ma_filter_mc
// Description : Multi-channel time-multiplexed moving-average filter with a
//               runtime power-of-two window and two-stage output pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ma_filter_mc #(
  parameter int  INPUT_WIDTH  = 16,
  parameter int  OUTPUT_WIDTH = 18,
  parameter int  MAX_ORDER    = 4,
  parameter int  CHANNELS     = 4,
  parameter int  SIGNED       = 0,
  parameter int  ROUND        = 0,
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int OW           = $clog2(MAX_ORDER + 1)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_chan,
  input  logic [INPUT_WIDTH-1:0]  data,
  input  logic [OW-1:0]           order,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [CW-1:0]           out_chan,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    out_full
);

  localparam int            DEPTH   = 1 << MAX_ORDER;
  localparam int            AW      = INPUT_WIDTH + MAX_ORDER;
  localparam logic [OW-1:0] MAX_ORD = OW'(MAX_ORDER);

  if (OUTPUT_WIDTH < INPUT_WIDTH) begin : g_bad_width
    $error("ma_filter_mc: OUTPUT_WIDTH must be >= INPUT_WIDTH");
  end
  if (MAX_ORDER < 1) begin : g_bad_order
    $error("ma_filter_mc: MAX_ORDER must be >= 1");
  end

  // Per-channel state
  logic [CHANNELS-1:0][DEPTH-1:0][INPUT_WIDTH-1:0] hist_q, hist_d;
  logic [CHANNELS-1:0][MAX_ORDER-1:0]              wp_q, wp_d;
  logic [CHANNELS-1:0][AW-1:0]                     acc_q, acc_d;
  logic [CHANNELS-1:0][MAX_ORDER:0]                fill_q, fill_d;
  logic [OW-1:0]                                   order_q, order_d;

  // Stage 1 registers
  logic                s1_valid_q, s1_valid_d;
  logic [CW-1:0]       s1_chan_q, s1_chan_d;
  logic [AW-1:0]       s1_sum_q, s1_sum_d;
  logic [OW-1:0]       s1_order_q, s1_order_d;
  logic                s1_full_q, s1_full_d;

  // Stage 2 (output) registers
  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_chan_q, out_chan_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                    out_full_q, out_full_d;

  logic                   chan_ok;
  logic [OW-1:0]          ord_c;
  logic                   flush;
  logic                   accept;
  logic [CW-1:0]          chan_idx;
  logic [MAX_ORDER:0]     win_n;
  logic [MAX_ORDER-1:0]   wp_cur;
  logic [MAX_ORDER-1:0]   rd_idx;
  logic [AW-1:0]          acc_cur;
  logic [AW-1:0]          acc_new;
  logic [MAX_ORDER:0]     fill_cur;
  logic [MAX_ORDER:0]     fill_new;
  logic [INPUT_WIDTH-1:0] x_old;
  logic                   x_sgn;
  logic                   old_sgn;
  logic [AW-1:0]          x_ext;
  logic [AW-1:0]          old_ext;

  if (CHANNELS == (1 << CW)) begin : g_chan_all
    assign chan_ok = 1'b1;
  end else begin : g_chan_chk
    assign chan_ok = ({1'b0, in_chan} < (CW + 1)'(CHANNELS));
  end

  // Stage 1: flush handling, history/accumulator update, window bookkeeping
  always_comb begin
    ord_c    = (order > MAX_ORD) ? MAX_ORD : order;
    flush    = clear || (ord_c != order_q);
    accept   = in_valid && chan_ok;
    chan_idx = accept ? in_chan : '0;
    win_n    = (MAX_ORDER + 1)'(1) << ord_c;

    // A flush zeroes state first so a same-cycle sample starts a fresh window
    hist_d  = flush ? '0 : hist_q;
    wp_d    = flush ? '0 : wp_q;
    acc_d   = flush ? '0 : acc_q;
    fill_d  = flush ? '0 : fill_q;
    order_d = ord_c;

    wp_cur   = wp_d[chan_idx];
    acc_cur  = acc_d[chan_idx];
    fill_cur = fill_d[chan_idx];
    rd_idx   = wp_cur - win_n[MAX_ORDER-1:0];
    x_old    = hist_d[chan_idx][rd_idx];

    x_sgn    = (SIGNED != 0) && data[INPUT_WIDTH-1];
    old_sgn  = (SIGNED != 0) && x_old[INPUT_WIDTH-1];
    x_ext    = {{MAX_ORDER{x_sgn}}, data};
    old_ext  = {{MAX_ORDER{old_sgn}}, x_old};
    acc_new  = acc_cur + x_ext - old_ext;
    fill_new = (fill_cur == (MAX_ORDER + 1)'(DEPTH)) ? fill_cur
                                                     : fill_cur + (MAX_ORDER + 1)'(1);

    if (accept) begin
      hist_d[chan_idx][wp_cur] = data;
      wp_d[chan_idx]           = wp_cur + MAX_ORDER'(1);
      acc_d[chan_idx]          = acc_new;
      fill_d[chan_idx]         = fill_new;
    end

    s1_valid_d = accept;
    s1_chan_d  = s1_chan_q;
    s1_sum_d   = s1_sum_q;
    s1_order_d = s1_order_q;
    s1_full_d  = s1_full_q;
    if (accept) begin
      s1_chan_d  = in_chan;
      s1_sum_d   = acc_new;
      s1_order_d = ord_c;
      s1_full_d  = (fill_new >= win_n);
    end
  end

  // Stage 2: round, shift, extend
  logic [AW:0]               sum_ext;
  logic [AW:0]               rnd;
  logic [AW:0]               sum_rnd;
  logic [INPUT_WIDTH-1:0]    mean;
  logic [OUTPUT_WIDTH-1:0]   mean_ext;

  always_comb begin
    sum_ext = {(SIGNED != 0) && s1_sum_q[AW-1], s1_sum_q};
    rnd     = '0;
    if ((ROUND != 0) && (s1_order_q != '0)) begin
      rnd = (AW + 1)'(1) << (s1_order_q - OW'(1));
    end
    sum_rnd = sum_ext + rnd;
    if (SIGNED != 0) begin
      mean = INPUT_WIDTH'($signed(sum_rnd) >>> s1_order_q);
    end else begin
      mean = INPUT_WIDTH'(sum_rnd >> s1_order_q);
    end
  end

  if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_ext
    assign mean_ext = {{(OUTPUT_WIDTH - INPUT_WIDTH){(SIGNED != 0) && mean[INPUT_WIDTH-1]}}, mean};
  end else begin : g_noext
    assign mean_ext = OUTPUT_WIDTH'(mean);
  end

  // Result fields hold between strobes
  always_comb begin
    out_valid_d = s1_valid_q;
    out_chan_d  = out_chan_q;
    result_d    = result_q;
    out_full_d  = out_full_q;
    if (s1_valid_q) begin
      out_chan_d = s1_chan_q;
      result_d   = mean_ext;
      out_full_d = s1_full_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hist_q      <= '0;
      wp_q        <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      order_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_chan_q   <= '0;
      s1_sum_q    <= '0;
      s1_order_q  <= '0;
      s1_full_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      result_q    <= '0;
      out_full_q  <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      wp_q        <= wp_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      order_q     <= order_d;
      s1_valid_q  <= s1_valid_d;
      s1_chan_q   <= s1_chan_d;
      s1_sum_q    <= s1_sum_d;
      s1_order_q  <= s1_order_d;
      s1_full_q   <= s1_full_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      result_q    <= result_d;
      out_full_q  <= out_full_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign result    = result_q;
  assign out_full  = out_full_q;

endmodule
`default_nettype wire

// File: tb/tb_ma_filter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ma_filter_mc
// Description : Self-checking bench for ma_filter_mc (unsigned, signed-floor
//               and signed-round instances driven by shared stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ma_filter_mc;

  logic        clk      = 1'b0;
  logic        nrst     = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_chan  = '0;
  logic [15:0] data     = '0;
  logic [2:0]  order    = '0;
  logic        clear    = 1'b0;

  logic        ov  [3];
  logic [2:0]  och [3];
  logic [17:0] res [3];
  logic        ofl [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instance 0: unsigned/floor, 1: signed/floor, 2: signed/round
  for (genvar k = 0; k < 3; k++) begin : g_dut
    ma_filter_mc #(
      .INPUT_WIDTH (16),
      .OUTPUT_WIDTH(18),
      .MAX_ORDER   (4),
      .CHANNELS    (5),
      .SIGNED      ((k > 0) ? 1 : 0),
      .ROUND       ((k == 2) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .nrst     (nrst),
      .in_valid (in_valid),
      .in_chan  (in_chan),
      .data     (data),
      .order    (order),
      .clear    (clear),
      .out_valid(ov[k]),
      .out_chan (och[k]),
      .result   (res[k]),
      .out_full (ofl[k])
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input string tag, input logic ev,
                           input logic [2:0] ech, input logic [17:0] eres, input logic ef);
    chk($sformatf("%s_u%0d_valid", tag, k), 32'(ov[k]), 32'(ev));
    if (ev) begin
      chk($sformatf("%s_u%0d_chan", tag, k), 32'(och[k]), 32'(ech));
      chk($sformatf("%s_u%0d_result", tag, k), 32'(res[k]), 32'(eres));
      chk($sformatf("%s_u%0d_full", tag, k), 32'(ofl[k]), 32'(ef));
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] ch, input logic [15:0] d,
                        input logic [2:0] o, input logic c);
    in_valid = v;
    in_chan  = ch;
    data     = d;
    order    = o;
    clear    = c;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: per-channel list of real samples since the last flush
  longint mq [3][8][$];
  int     m_prev;
  logic        e_v  [3];
  logic [2:0]  e_ch [3];
  logic [17:0] e_res[3];
  logic        e_full[3];

  task automatic model_step(input logic v, input logic [2:0] ch, input logic [15:0] d,
                            input logic [2:0] o, input logic c);
    int     oc;
    int     cnt;
    longint n, sum, num, q;
    oc = (o > 3'd4) ? 4 : int'(o);
    if (c || (oc != m_prev)) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 8; j++) mq[k][j].delete();
    end
    m_prev = oc;
    for (int k = 0; k < 3; k++) begin
      e_v[k]    = v && (ch < 3'd5);
      e_ch[k]   = ch;
      e_res[k]  = '0;
      e_full[k] = 1'b0;
      if (e_v[k]) begin
        mq[k][ch].push_back((k > 0) ? longint'($signed(d)) : longint'(d));
        if (mq[k][ch].size() > 16) void'(mq[k][ch].pop_front());
        n   = longint'(1) << oc;
        cnt = mq[k][ch].size();
        sum = 0;
        for (int j = 0; j < n && j < cnt; j++) sum += mq[k][ch][cnt-1-j];
        num = sum + (((k == 2) && (oc > 0)) ? n / 2 : 0);
        q   = num / n;
        if (((num % n) != 0) && (num < 0)) q = q - 1;
        e_res[k]  = q[17:0];
        e_full[k] = (cnt >= n);
      end
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  ch;
    logic [15:0] d;
    logic [2:0]  o;
    logic        c;
    logic        ev;
    logic [17:0] er;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [2:0] ch, input logic [15:0] d, input logic [2:0] o,
                     input logic c, input logic ev, input logic [17:0] er, input logic ef);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.o = o; r.c = c; r.ev = ev; r.er = er; r.ef = ef;
    tbl.push_back(r);
  endtask

  initial begin
    logic        pv;
    logic [2:0]  pch;
    logic [17:0] pres;
    logic        pf;
    logic        p_v  [3];
    logic [2:0]  p_ch [3];
    logic [17:0] p_res[3];
    logic        p_f  [3];
    logic [15:0] sdat [4];
    logic        sclr [4];
    logic [17:0] sexp [3][4];
    logic        sful [4];
    logic        rv, rc;
    logic [2:0]  rch, ro;
    logic [15:0] rd;

    // Window of four: constant 100 ramps up
    for (int i = 1; i <= 5; i++) add(1, 0, 16'd100, 2, 0, 1, 18'(25 * ((i < 4) ? i : 4)), i >= 4);
    // Interleaved channels with an out-of-range channel in between
    add(1, 0, 16'd1000, 1, 0, 1, 18'd500, 0);
    add(1, 1, 16'd0, 1, 0, 1, 18'd0, 0);
    add(1, 5, 16'd777, 1, 0, 0, 18'd0, 0);
    add(1, 0, 16'd1000, 1, 0, 1, 18'd1000, 1);
    add(1, 1, 16'd0, 1, 0, 1, 18'd0, 1);
    add(1, 0, 16'd1000, 1, 0, 1, 18'd1000, 1);
    // Order change and explicit clear flushes
    add(1, 0, 16'd80, 2, 0, 1, 18'd20, 0);
    add(1, 0, 16'd80, 2, 0, 1, 18'd40, 0);
    add(1, 0, 16'd80, 3, 0, 1, 18'd10, 0);
    add(1, 2, 16'd40, 2, 1, 1, 18'd10, 0);
    add(1, 0, 16'd80, 2, 0, 1, 18'd20, 0);
    // Clamped order 7 -> 4 with full-scale samples, then order 4 keeps the window
    for (int k = 1; k <= 16; k++) add(1, 3, 16'hFFFF, 7, 0, 1, 18'((k * 65535) / 16), k == 16);
    add(1, 3, 16'd0, 4, 0, 1, 18'd61439, 1);

    // Reset state
    set_in(0, 0, 0, 2, 0);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_u%0d_valid", k), 32'(ov[k]), 0);
      chk($sformatf("reset_u%0d_chan", k), 32'(och[k]), 0);
      chk($sformatf("reset_u%0d_result", k), 32'(res[k]), 0);
      chk($sformatf("reset_u%0d_full", k), 32'(ofl[k]), 0);
    end
    nrst = 1'b1;
    tick();

    // Table vectors on the unsigned instance, each checked one step later
    pv = 1'b0; pch = '0; pres = '0; pf = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].o, tbl[i].c);
      tick();
      check_dut(0, $sformatf("tbl%0d", i - 1), pv, pch, pres, pf);
      pv = tbl[i].ev; pch = tbl[i].ch; pres = tbl[i].er; pf = tbl[i].ef;
    end
    set_in(0, 0, 0, 4, 0);
    tick();
    check_dut(0, $sformatf("tbl%0d", tbl.size() - 1), pv, pch, pres, pf);

    // Signed floor vs round, order 1
    sdat = '{16'hFFFD, 16'h0000, 16'hFFFC, 16'hFFFC};
    sclr = '{1'b1, 1'b0, 1'b1, 1'b0};
    sful = '{1'b0, 1'b1, 1'b0, 1'b1};
    sexp[0] = '{18'd32766, 18'd32766, 18'd32766, 18'd65532};
    sexp[1] = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFE, 18'h3FFFC};
    sexp[2] = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 18'h3FFFC};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) set_in(1, 0, sdat[i], 1, sclr[i]);
      else       set_in(0, 0, 0, 1, 0);
      tick();
      for (int k = 0; k < 3; k++)
        if (i == 0) check_dut(k, "sgn_pre", 1'b0, 3'd0, 18'd0, 1'b0);
        else        check_dut(k, $sformatf("sgn%0d", i - 1), 1'b1, 3'd0, sexp[k][i-1], sful[i-1]);
    end

    // Asynchronous reset with two samples in flight
    set_in(1, 0, 16'd100, 2, 0);
    tick();
    chk("arst_idle_valid", 32'(ov[0]), 0);
    set_in(1, 0, 16'd100, 2, 0);
    @(posedge clk);
    set_in(0, 0, 0, 2, 0);
    #2;
    chk("arst_pre_valid", 32'(ov[0]), 1);
    chk("arst_pre_result", 32'(res[0]), 25);
    nrst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_u%0d_valid", k), 32'(ov[k]), 0);
      chk($sformatf("arst_u%0d_result", k), 32'(res[k]), 0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("arst_hold%0d_valid", c), 32'(ov[0]), 0);
    end
    nrst = 1'b1;
    tick();
    chk("arst_late_valid", 32'(ov[0]), 0);
    set_in(1, 0, 16'd100, 2, 0);
    tick();
    chk("arst_post_lat", 32'(ov[0]), 0);
    set_in(0, 0, 0, 2, 0);
    tick();
    check_dut(0, "arst_post", 1'b1, 3'd0, 18'd25, 1'b0);

    // Randomized stimulus against the model, all three instances
    ro = 3'd2;
    set_in(0, 0, 0, ro, 1);
    model_step(0, 0, 0, ro, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      p_v[k] = e_v[k]; p_ch[k] = e_ch[k]; p_res[k] = e_res[k]; p_f[k] = e_full[k];
    end
    for (int it = 0; it <= 800; it++) begin
      if (it < 800) begin
        rv  = ($urandom_range(3) != 0);
        rch = 3'($urandom_range(7));
        case ($urandom_range(7))
          0:       rd = 16'hFFFF;
          1:       rd = 16'h8000;
          2:       rd = 16'h7FFF;
          3:       rd = 16'h0000;
          default: rd = 16'($urandom);
        endcase
        if ($urandom_range(39) == 0) ro = 3'($urandom_range(7));
        rc = ($urandom_range(49) == 0);
      end else begin
        rv = 1'b0; rch = '0; rd = '0; rc = 1'b0;
      end
      set_in(rv, rch, rd, ro, rc);
      model_step(rv, rch, rd, ro, rc);
      tick();
      for (int k = 0; k < 3; k++) begin
        check_dut(k, "rnd", p_v[k], p_ch[k], p_res[k], p_f[k]);
        p_v[k] = e_v[k]; p_ch[k] = e_ch[k]; p_res[k] = e_res[k]; p_f[k] = e_full[k];
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
